writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of pending write entries (power of two, 2..8).
REQ-002 The block SHALL have parameter XLEN, default 32, meaning the register data width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  a producer offers a write request.
REQ-006 The block SHALL have port in_ready  output  1  the queue can accept a request this cycle.
REQ-007 The block SHALL have port in_rd  input  5  destination register index.
REQ-008 The block SHALL have port in_data  input  XLEN  write data.
REQ-009 The block SHALL have port drain_en  input  1  the register file write port is available this cycle.
REQ-010 The block SHALL have port rf_we  output  1  write enable to the register file.
REQ-011 The block SHALL have port rf_a3  output  5  write address to the register file.
REQ-012 The block SHALL have port rf_wd  output  XLEN  write data to the register file.
REQ-013 The block SHALL have ports fwd_a1 and fwd_a2  input  5 each  read addresses presented by decode.
REQ-014 The block SHALL have ports fwd_hit1 and fwd_hit2  output  1 each  a pending entry matches the address.
REQ-015 The block SHALL have ports fwd_data1 and fwd_data2  output  XLEN each  data of the matching entry.
REQ-016 The block SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 Enqueue SHALL occur at the posedge where in_valid && in_ready; in_ready SHALL be high iff count < DEPTH.
REQ-018 An accepted request with in_rd == 0 SHALL be discarded: it is not stored and count does not change.
REQ-019 Dequeue SHALL occur at the posedge where rf_we is high; rf_we SHALL equal (count != 0) && drain_en, combinationally.
REQ-020 rf_a3 and rf_wd SHALL present the oldest entry whenever count != 0, and SHALL be 0 when count == 0.
REQ-021 Latency: a request accepted at posedge N SHALL appear on rf_we/rf_a3/rf_wd in the cycle after posedge N when the queue was empty and drain_en is high, so the register file captures it at the following negedge.
REQ-022 Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve FIFO order.
REQ-023 A full queue SHALL NOT accept a request in the same cycle it drains; in_ready depends only on registered count.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 fwd_hitX SHALL be high iff fwd_aX != 0 and some occupied entry (head included) has rd == fwd_aX.
REQ-026 On multiple matches, fwd_dataX SHALL return the newest matching entry; with no match, fwd_dataX SHALL be 0.
REQ-027 Forwarding SHALL be combinational on current queue contents and SHALL NOT include the request being enqueued in the same cycle.
REQ-028 drain_en low SHALL hold all entries; enqueue SHALL continue until full.

Reset
REQ-029 Asserting rst low SHALL immediately clear count and both pointers; in_ready, rf_we, rf_a3, rf_wd, fwd_hit1/2, fwd_data1/2 SHALL read 1,0,0,0,0,0 while count == 0.
REQ-030 Reset asserted mid-operation SHALL drop all pending entries without issuing register file writes; entry storage need not be cleared.
REQ-031 The first enqueue SHALL be possible at the first posedge after rst deasserts.

Structure
REQ-032 The shared package SHALL hold XLEN, the register index width (5), and the zero-register index constant.
REQ-033 The design SHALL be one module with one sub-module, wbq_match, a priority matcher returning the newest matching entry for one address; it is instantiated twice.

Verification
REQ-034 Reset, then enqueue rd=5/0xDEADBEEF with drain_en=1 -> next cycle rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF; the cycle after, count=0.
REQ-035 drain_en=0; enqueue rd=1..4 with data 0x11..0x44 -> count=4, in_ready=0; a 5th request is stalled; set drain_en=1 -> writes 1,2,3,4 in order on consecutive cycles.
REQ-036 Enqueue rd=7/0xA then rd=7/0xB, drain_en=0, fwd_a1=7 -> fwd_hit1=1, fwd_data1=0xB; fwd_a2=8 -> fwd_hit2=0, fwd_data2=0.
REQ-037 Enqueue rd=0/0x1234 -> count stays 0, rf_we stays 0; fwd_a1=0 -> fwd_hit1=0.
REQ-038 Queue holds 3 entries, rst pulsed low between edges -> count=0, rf_we=0 immediately; no further writes after release.
REQ-039 count=2, in_valid=1 and drain_en=1 for 6 cycles -> count remains 2; output order matches input order across pointer wrap.

Source files
------------

// File: rtl/writeback_queue_pkg.sv
// Shared constants for the writeback queue: data width, register index width
// and the hard-wired zero register index.
package writeback_queue_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/wbq_match.sv
// Priority matcher: scans the occupied queue entries from oldest to newest and
// returns the newest entry whose destination register equals addr_i.
module wbq_match
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = writeback_queue_pkg::XLEN
) (
  input  logic [DEPTH-1:0][REG_IDX_W-1:0] entry_rd_i,
  input  logic [DEPTH-1:0][XLEN-1:0]      entry_data_i,
  input  logic [$clog2(DEPTH)-1:0]        head_i,
  input  logic [$clog2(DEPTH):0]          count_i,
  input  logic [REG_IDX_W-1:0]            addr_i,
  output logic                            hit_o,
  output logic [XLEN-1:0]                 data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Walk entries in age order so that a later match overrides an earlier one.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments with defaults first,
    // so no latch is inferred and the last assignment in the loop wins.
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_i) && (addr_i != ZERO_REG) &&
          (entry_rd_i[head_i + PTR_W'(k)] == addr_i)) begin
        hit_o  = 1'b1;
        data_o = entry_data_i[head_i + PTR_W'(k)];
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: buffers register file writes in FIFO order, drains one per
// cycle when the write port is free, and forwards pending data to decode.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = writeback_queue_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_IDX_W-1:0]     in_rd,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     drain_en,
  output logic                     rf_we,
  output logic [REG_IDX_W-1:0]     rf_a3,
  output logic [XLEN-1:0]          rf_wd,
  input  logic [REG_IDX_W-1:0]     fwd_a1,
  input  logic [REG_IDX_W-1:0]     fwd_a2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [XLEN-1:0]          fwd_data1,
  output logic [XLEN-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0][REG_IDX_W-1:0] entry_rd_q;
  logic [DEPTH-1:0][XLEN-1:0]      entry_data_q;

  logic not_empty;
  logic accept;
  logic store;

  // in_ready looks only at the registered count, so a full queue never takes
  // a request in the same cycle it drains.
  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign store     = accept && (in_rd != ZERO_REG);

  assign rf_we = not_empty && drain_en;
  assign rf_a3 = not_empty ? entry_rd_q[rd_ptr_q]   : '0;
  assign rf_wd = not_empty ? entry_data_q[rd_ptr_q] : '0;
  assign count = count_q;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = store ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rf_we ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({store, rf_we})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: cleared immediately by reset, which drops all entries.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written at the tail on every stored enqueue.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; count_q alone decides which
    // entries are live, so stale contents are never observed.
    if (store) begin
      entry_rd_q[wr_ptr_q]   <= in_rd;
      entry_data_q[wr_ptr_q] <= in_data;
    end
  end

  wbq_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_match1 (
    .entry_rd_i   (entry_rd_q),
    .entry_data_i (entry_data_q),
    .head_i       (rd_ptr_q),
    .count_i      (count_q),
    .addr_i       (fwd_a1),
    .hit_o        (fwd_hit1),
    .data_o       (fwd_data1)
  );

  wbq_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_match2 (
    .entry_rd_i   (entry_rd_q),
    .entry_data_i (entry_data_q),
    .head_i       (rd_ptr_q),
    .count_i      (count_q),
    .addr_i       (fwd_a2),
    .hit_o        (fwd_hit2),
    .data_o       (fwd_data2)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: a table of per-cycle vectors plus
// hand-written sequences for pointer wrap and mid-operation reset.
module tb_writeback_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        drain_en;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [4:0]  fwd_a1;
  logic [4:0]  fwd_a2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  writeback_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .drain_en  (drain_en),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd     (rf_wd),
    .fwd_a1    (fwd_a1),
    .fwd_a2    (fwd_a2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        de;
    logic [4:0]  fa1;
    logic [4:0]  fa2;
    logic        e_ready;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic [2:0]  e_count;
    logic        e_hit1;
    logic [31:0] e_d1;
    logic        e_hit2;
    logic [31:0] e_d2;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then let outputs settle.
  task automatic drive(input logic iv, input logic [4:0] rd, input logic [31:0] data,
                       input logic de, input logic [4:0] fa1, input logic [4:0] fa2);
    @(negedge clk);
    in_valid = iv;
    in_rd    = rd;
    in_data  = data;
    drain_en = de;
    fwd_a1   = fa1;
    fwd_a2   = fa2;
    #1;
  endtask

  initial begin
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    drain_en = 1'b0;
    fwd_a1   = 5'd5;
    fwd_a2   = '0;
    rst      = 1'b1;
    #1 rst   = 1'b0;
    #2;

    // Reset state
    check("rst_count",  32'(count),    32'd0);
    check("rst_ready",  32'(in_ready), 32'd1);
    check("rst_we",     32'(rf_we),    32'd0);
    check("rst_a3",     32'(rf_a3),    32'd0);
    check("rst_wd",     rf_wd,         32'd0);
    check("rst_hit1",   32'(fwd_hit1), 32'd0);
    check("rst_data1",  fwd_data1,     32'd0);
    #9 rst = 1'b1;

    //               iv rd     data          de fa1    fa2    rdy we a3     wd            cnt h1 d1            h2 d2
    vecs.push_back('{1, 5'd5,  32'hDEADBEEF, 1, 5'd0,  5'd0,  1,  0, 5'd0,  32'h0,        0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{0, 5'd0,  32'h0,        1, 5'd5,  5'd0,  1,  1, 5'd5,  32'hDEADBEEF, 1,  1, 32'hDEADBEEF, 0, 32'h0});
    vecs.push_back('{0, 5'd0,  32'h0,        1, 5'd5,  5'd0,  1,  0, 5'd0,  32'h0,        0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 5'd1,  32'h11,       0, 5'd0,  5'd0,  1,  0, 5'd0,  32'h0,        0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 5'd2,  32'h22,       0, 5'd1,  5'd0,  1,  0, 5'd1,  32'h11,       1,  1, 32'h11,       0, 32'h0});
    vecs.push_back('{1, 5'd3,  32'h33,       0, 5'd0,  5'd2,  1,  0, 5'd1,  32'h11,       2,  0, 32'h0,        1, 32'h22});
    vecs.push_back('{1, 5'd4,  32'h44,       0, 5'd0,  5'd0,  1,  0, 5'd1,  32'h11,       3,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 5'd9,  32'h99,       0, 5'd3,  5'd9,  0,  0, 5'd1,  32'h11,       4,  1, 32'h33,       0, 32'h0});
    vecs.push_back('{1, 5'd9,  32'h99,       1, 5'd4,  5'd0,  0,  1, 5'd1,  32'h11,       4,  1, 32'h44,       0, 32'h0});
    vecs.push_back('{0, 5'd0,  32'h0,        1, 5'd0,  5'd0,  1,  1, 5'd2,  32'h22,       3,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{0, 5'd0,  32'h0,        1, 5'd1,  5'd0,  1,  1, 5'd3,  32'h33,       2,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{0, 5'd0,  32'h0,        1, 5'd0,  5'd0,  1,  1, 5'd4,  32'h44,       1,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{0, 5'd0,  32'h0,        1, 5'd4,  5'd0,  1,  0, 5'd0,  32'h0,        0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 5'd7,  32'hA,        0, 5'd0,  5'd0,  1,  0, 5'd0,  32'h0,        0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 5'd7,  32'hB,        0, 5'd7,  5'd0,  1,  0, 5'd7,  32'hA,        1,  1, 32'hA,        0, 32'h0});
    vecs.push_back('{0, 5'd0,  32'h0,        0, 5'd7,  5'd8,  1,  0, 5'd7,  32'hA,        2,  1, 32'hB,        0, 32'h0});
    vecs.push_back('{0, 5'd0,  32'h0,        1, 5'd7,  5'd7,  1,  1, 5'd7,  32'hA,        2,  1, 32'hB,        1, 32'hB});
    vecs.push_back('{0, 5'd0,  32'h0,        1, 5'd7,  5'd0,  1,  1, 5'd7,  32'hB,        1,  1, 32'hB,        0, 32'h0});
    vecs.push_back('{1, 5'd0,  32'h1234,     1, 5'd0,  5'd0,  1,  0, 5'd0,  32'h0,        0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{0, 5'd0,  32'h0,        1, 5'd0,  5'd0,  1,  0, 5'd0,  32'h0,        0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 5'd12, 32'h55,       0, 5'd12, 5'd0,  1,  0, 5'd0,  32'h0,        0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{0, 5'd0,  32'h0,        0, 5'd12, 5'd0,  1,  0, 5'd12, 32'h55,       1,  1, 32'h55,       0, 32'h0});
    vecs.push_back('{0, 5'd0,  32'h0,        1, 5'd0,  5'd12, 1,  1, 5'd12, 32'h55,       1,  0, 32'h0,        1, 32'h55});
    vecs.push_back('{0, 5'd0,  32'h0,        1, 5'd0,  5'd0,  1,  0, 5'd0,  32'h0,        0,  0, 32'h0,        0, 32'h0});

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].rd, vecs[i].data, vecs[i].de, vecs[i].fa1, vecs[i].fa2);
      check($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d_we",    i), 32'(rf_we),    32'(vecs[i].e_we));
      check($sformatf("v%0d_a3",    i), 32'(rf_a3),    32'(vecs[i].e_a3));
      check($sformatf("v%0d_wd",    i), rf_wd,         vecs[i].e_wd);
      check($sformatf("v%0d_count", i), 32'(count),    32'(vecs[i].e_count));
      check($sformatf("v%0d_hit1",  i), 32'(fwd_hit1), 32'(vecs[i].e_hit1));
      check($sformatf("v%0d_data1", i), fwd_data1,     vecs[i].e_d1);
      check($sformatf("v%0d_hit2",  i), 32'(fwd_hit2), 32'(vecs[i].e_hit2));
      check($sformatf("v%0d_data2", i), fwd_data2,     vecs[i].e_d2);
    end

    // Steady state at count=2 with simultaneous enqueue/dequeue across wrap.
    drive(1, 5'd10, 32'h100, 0, 5'd0, 5'd0);
    drive(1, 5'd11, 32'h101, 0, 5'd0, 5'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 5'(12 + i), 32'h102 + 32'(i), 1, 5'd0, 5'd0);
      check($sformatf("wrap%0d_count", i), 32'(count),    32'd2);
      check($sformatf("wrap%0d_we",    i), 32'(rf_we),    32'd1);
      check($sformatf("wrap%0d_ready", i), 32'(in_ready), 32'd1);
      check($sformatf("wrap%0d_a3",    i), 32'(rf_a3),    32'(10 + i));
      check($sformatf("wrap%0d_wd",    i), rf_wd,         32'h100 + 32'(i));
    end
    for (int j = 0; j < 2; j++) begin
      drive(0, 5'd0, 32'h0, 1, 5'd0, 5'd0);
      check($sformatf("tail%0d_a3", j), 32'(rf_a3), 32'(16 + j));
      check($sformatf("tail%0d_wd", j), rf_wd,      32'h106 + 32'(j));
    end
    drive(0, 5'd0, 32'h0, 1, 5'd0, 5'd0);
    check("wrap_empty_count", 32'(count), 32'd0);
    check("wrap_empty_we",    32'(rf_we), 32'd0);

    // Mid-operation reset with three pending entries.
    drive(1, 5'd20, 32'h200, 0, 5'd0, 5'd0);
    drive(1, 5'd21, 32'h201, 0, 5'd0, 5'd0);
    drive(1, 5'd22, 32'h202, 0, 5'd0, 5'd0);
    drive(1, 5'd3,  32'h77,  1, 5'd21, 5'd0);
    check("prerst_count", 32'(count),    32'd3);
    check("prerst_we",    32'(rf_we),    32'd1);
    check("prerst_hit1",  32'(fwd_hit1), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("midrst_count", 32'(count),    32'd0);
    check("midrst_we",    32'(rf_we),    32'd0);
    check("midrst_a3",    32'(rf_a3),    32'd0);
    check("midrst_wd",    rf_wd,         32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_hit1",  32'(fwd_hit1), 32'd0);
    check("midrst_data1", fwd_data1,     32'd0);
    #1 rst = 1'b1;
    // The request held on the inputs is taken at the first posedge after release.
    drive(0, 5'd0, 32'h0, 1, 5'd21, 5'd0);
    check("postrst_count", 32'(count),    32'd1);
    check("postrst_we",    32'(rf_we),    32'd1);
    check("postrst_a3",    32'(rf_a3),    32'd3);
    check("postrst_wd",    rf_wd,         32'h77);
    check("postrst_hit1",  32'(fwd_hit1), 32'd0);
    for (int j = 0; j < 3; j++) begin
      drive(0, 5'd0, 32'h0, 1, 5'd0, 5'd0);
      check($sformatf("postrst%0d_we",    j), 32'(rf_we), 32'd0);
      check($sformatf("postrst%0d_count", j), 32'(count), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
